// File: rtl/mkio_rt_core.sv
// mkio_rt_core: MKIO remote-terminal message engine; define MKIO_BCAST_EN to accept broadcast address 31
module mkio_rt_core #(
  parameter logic [4:0]  ADDRESS    = 5'd1,
  parameter int          NUM_SA     = 4,
  parameter logic [7:0]  STATUS_GAP = 8'd4,
  parameter logic [15:0] TIMEOUT    = 16'd1000,
  localparam int         PW         = NUM_SA > 1 ? $clog2(NUM_SA) : 1,
  localparam int         AW         = PW + 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_done,
  input  logic [15:0]   rx_data,
  input  logic          rx_cd,
  input  logic          p_error,
  output logic [15:0]   tx_data,
  output logic          tx_cd,
  output logic          tx_ready,
  input  logic          tx_busy,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  output logic          mem_we,
  input  logic [15:0]   mem_rdata,
  output logic          busy,
  output logic          msg_done,
  output logic          msg_err
);
`ifdef MKIO_BCAST_EN
  localparam logic BCAST = 1'b1;
`else
  localparam logic BCAST = 1'b0;
`endif
  typedef enum logic [3:0] {IDLE, DECODE, RX_WAIT, RX_SAVE, GAP, SEND_STATUS, ST_WAIT, TX_FETCH, TX_SEND, TX_WAIT, DONE} state_t;
  state_t state;
  logic [10:0] cmd;
  logic [4:0] cnt, sa, last;
  logic [7:0] gcnt;
  logic [15:0] tmo;
  logic [PW-1:0] page;
  logic pend, bc, fph, tr, mode, ill, bc_addr, hit;
  always_comb begin
    tr = cmd[10];
    sa = cmd[9:5];
    last = cmd[4:0] - 5'd1;
    page = PW'(sa - 5'd1);
    mode = sa == 5'd0 || sa == 5'd31;
    ill = !mode && int'(sa) > NUM_SA;
    bc_addr = BCAST && rx_data[15:11] == 5'd31;
    hit = rx_done && rx_cd && !p_error && (rx_data[15:11] == ADDRESS || bc_addr);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cmd <= '0;
      cnt <= '0;
      gcnt <= '0;
      tmo <= '0;
      pend <= 1'b0;
      bc <= 1'b0;
      fph <= 1'b0;
      tx_data <= '0;
      tx_cd <= 1'b0;
      tx_ready <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_we <= 1'b0;
      busy <= 1'b0;
      msg_done <= 1'b0;
      msg_err <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      msg_done <= 1'b0;
      if (hit && (state == IDLE || state == RX_WAIT)) begin
        cmd <= rx_data[10:0];
        bc <= bc_addr;
      end
      case (state)
        IDLE: if (hit || pend) begin
          pend <= 1'b0;
          state <= DECODE;
        end
        DECODE: begin
          busy <= 1'b1;
          msg_err <= ill || (bc && tr);
          cnt <= '0;
          gcnt <= '0;
          tmo <= '0;
          state <= bc && tr ? DONE : !tr && !mode ? RX_WAIT : bc ? DONE : GAP;
        end
        RX_WAIT: begin
          if (rx_done && rx_cd) begin
            pend <= hit;
            busy <= 1'b0;
            state <= IDLE;
          end else if (rx_done) begin
            mem_we <= !ill;
            mem_addr <= {page, cnt};
            mem_wdata <= rx_data;
            msg_err <= msg_err | p_error;
            state <= RX_SAVE;
          end else if (tmo == TIMEOUT - 16'd1) begin
            msg_err <= 1'b1;
            busy <= 1'b0;
            state <= IDLE;
          end else tmo <= tmo + 16'd1;
        end
        RX_SAVE: begin
          if (cnt == last) state <= bc ? DONE : GAP;
          else begin
            cnt <= cnt + 5'd1;
            tmo <= '0;
            state <= RX_WAIT;
          end
        end
        GAP: begin
          if (gcnt + 8'd1 >= STATUS_GAP) begin
            tx_data <= {ADDRESS, msg_err, 10'd0};
            tx_cd <= 1'b1;
            tx_ready <= 1'b1;
            state <= SEND_STATUS;
          end else gcnt <= gcnt + 8'd1;
        end
        SEND_STATUS, TX_SEND: if (tx_busy) begin
          tx_ready <= 1'b0;
          state <= state == SEND_STATUS ? ST_WAIT : TX_WAIT;
        end
        ST_WAIT: if (!tx_busy) begin
          if (tr && !ill && !mode) begin
            mem_addr <= {page, cnt};
            fph <= 1'b0;
            state <= TX_FETCH;
          end else state <= DONE;
        end
        TX_FETCH: begin
          fph <= 1'b1;
          if (fph) begin
            tx_data <= mem_rdata;
            tx_cd <= 1'b0;
            tx_ready <= 1'b1;
            state <= TX_SEND;
          end
        end
        TX_WAIT: if (!tx_busy) begin
          if (cnt == last) state <= DONE;
          else begin
            cnt <= cnt + 5'd1;
            mem_addr <= {page, cnt + 5'd1};
            fph <= 1'b0;
            state <= TX_FETCH;
          end
        end
        DONE: begin
          busy <= 1'b0;
          msg_done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mkio_rt_core.sv
// tb_mkio_rt_core: randomized self-checking bench with a message-level reference model
`timescale 1ns/1ps
module tb_mkio_rt_core;
  localparam logic [4:0] ADDR = 5'd1;
  localparam int NSA = 4;
  localparam int GAPC = 4;
  localparam int AW = 7;
`ifdef MKIO_BCAST_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, rx_done = 1'b0, rx_cd = 1'b0, p_error = 1'b0, tx_busy = 1'b0;
  logic [15:0] rx_data = '0, tx_data, mem_wdata, mem_rdata = '0;
  logic tx_cd, tx_ready, mem_we, busy, msg_done, msg_err;
  logic [AW-1:0] mem_addr;
  logic [15:0] mem [128];
  logic [22:0] wq[$];
  logic [16:0] txq[$];
  int done_cnt = 0, rdy_seen = 0, hs_bad = 0, bcnt = 0;
  int checks = 0, errors = 0;
  logic m_err = 1'b0;
  mkio_rt_core #(.ADDRESS(ADDR), .NUM_SA(NSA), .STATUS_GAP(8'(GAPC)), .TIMEOUT(16'd1000)) dut (
    .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data), .rx_cd(rx_cd), .p_error(p_error),
    .tx_data(tx_data), .tx_cd(tx_cd), .tx_ready(tx_ready), .tx_busy(tx_busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy), .msg_done(msg_done), .msg_err(msg_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) mem_rdata <= mem[mem_addr];
  always @(negedge clk) begin
    if (mem_we) wq.push_back({mem_addr, mem_wdata});
    if (msg_done) done_cnt++;
    if (tx_ready) rdy_seen++;
  end
  initial forever begin
    @(negedge clk);
    if (tx_ready && tx_busy) hs_bad++;
    if (tx_busy) begin
      if (bcnt == 0) tx_busy = 1'b0;
      else bcnt--;
    end else if (tx_ready) begin
      txq.push_back({tx_cd, tx_data});
      tx_busy = 1'b1;
      bcnt = $urandom_range(1, 4);
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send_word(input logic [15:0] d, input logic cd, input logic pe);
    @(negedge clk);
    rx_data = d;
    rx_cd = cd;
    p_error = pe;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    p_error = 1'b0;
  endtask
  task automatic wait_done(input string tag, input int db);
    int k;
    k = 0;
    while (done_cnt == db && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done"}, done_cnt - db, 1);
  endtask
  task automatic do_msg(input string tag, input logic [15:0] cmd, input logic [31:0] pmask, input bit cperr);
    logic [15:0] w[32];
    logic [22:0] ew;
    logic [16:0] et[$];
    bit tr, mode, ill, bcast, ours, rxd, err;
    int n, pg, wb, tb, db, k, nw;
    tr = cmd[10];
    n = cmd[4:0] == 5'd0 ? 32 : int'(cmd[4:0]);
    pg = int'(cmd[9:5]) - 1;
    mode = cmd[9:5] == 5'd0 || cmd[9:5] == 5'd31;
    ill = !mode && int'(cmd[9:5]) > NSA;
    bcast = BC && cmd[15:11] == 5'd31;
    ours = !cperr && (cmd[15:11] == ADDR || bcast);
    rxd = !tr && !mode;
    err = ill || (bcast && tr);
    for (int i = 0; i < n; i++) begin
      w[i] = 16'($urandom);
      if (rxd && pmask[i]) err = 1'b1;
    end
    wb = wq.size();
    tb = txq.size();
    db = done_cnt;
    send_word(cmd, 1'b1, cperr);
    if (rxd) for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_word(w[i], 1'b0, pmask[i]);
    end
    if (ours && rxd && !bcast) begin
      k = 0;
      while (!tx_ready && k < GAPC + 4) begin
        @(negedge clk);
        k++;
      end
      chk({tag, "_gap"}, 32'(k > GAPC && tx_ready), 1);
    end
    if (ours) wait_done(tag, db);
    else repeat (40) @(negedge clk);
    repeat (3) @(negedge clk);
    nw = ours && rxd && !ill ? n : 0;
    chk({tag, "_wr_cnt"}, wq.size() - wb, nw);
    for (int i = 0; i < nw && wb + i < wq.size(); i++) begin
      ew = {AW'(pg * 32 + i), w[i]};
      chk({tag, "_wr"}, 32'(wq[wb + i]), 32'(ew));
    end
    if (ours && !bcast) begin
      et.push_back({1'b1, ADDR, err, 10'd0});
      if (tr && !mode && !ill) for (int i = 0; i < n; i++) et.push_back({1'b0, mem[pg * 32 + i]});
    end
    chk({tag, "_tx_cnt"}, txq.size() - tb, et.size());
    for (int i = 0; i < et.size() && tb + i < txq.size(); i++) chk({tag, "_tx"}, 32'(txq[tb + i]), 32'(et[i]));
    if (ours) m_err = err;
    chk({tag, "_err"}, 32'(msg_err), 32'(m_err));
    chk({tag, "_busy"}, 32'(busy), 0);
    if (!ours) chk({tag, "_nodone"}, done_cnt - db, 0);
  endtask
  initial begin
    int wb, tb, db, rs;
    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1234;
    mem[1] = 16'h5678;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(msg_done), 0);
    chk("rst_err", 32'(msg_err), 0);
    chk("rst_ready", 32'(tx_ready), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_txdata", 32'(tx_data), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    do_msg("rx3", 16'h0843, 0, 1'b0);
    do_msg("tx2", 16'h0C22, 0, 1'b0);
    do_msg("wc32", 16'h0880, 0, 1'b0);
    do_msg("perr", 16'h0843, 32'h2, 1'b0);
    do_msg("cmd_perr", 16'h0843, 0, 1'b1);
    do_msg("ill_rx", 16'h0922, 0, 1'b0);
    do_msg("ill_tx", 16'h0D22, 0, 1'b0);
    do_msg("mode_rx", 16'h0801, 0, 1'b0);
    do_msg("bcast_rx", 16'hF822, 0, 1'b0);
    do_msg("bcast_tx", 16'hFC22, 0, 1'b0);
    do_msg("other", 16'h1043, 0, 1'b0);
    wb = wq.size();
    db = done_cnt;
    rs = rdy_seen;
    send_word(16'h0843, 1'b1, 1'b0);
    send_word(16'h0001, 1'b0, 1'b0);
    send_word(16'h0002, 1'b0, 1'b0);
    repeat (950) @(negedge clk);
    chk("to_early", 32'(busy), 1);
    repeat (150) @(negedge clk);
    chk("to_wr", wq.size() - wb, 2);
    chk("to_busy", 32'(busy), 0);
    chk("to_err", 32'(msg_err), 1);
    chk("to_rdy", rdy_seen - rs, 0);
    chk("to_done", done_cnt - db, 0);
    m_err = 1'b1;
    wb = wq.size();
    tb = txq.size();
    db = done_cnt;
    send_word(16'h0843, 1'b1, 1'b0);
    send_word(16'hBEEF, 1'b0, 1'b0);
    send_word(16'h0C22, 1'b1, 1'b0);
    wait_done("abort", db);
    repeat (3) @(negedge clk);
    chk("abort_wr_cnt", wq.size() - wb, 1);
    if (wq.size() > wb) chk("abort_wr", 32'(wq[wb]), 32'({7'h20, 16'hBEEF}));
    chk("abort_tx_cnt", txq.size() - tb, 3);
    if (txq.size() >= tb + 3) begin
      chk("abort_st", 32'(txq[tb]), 32'({1'b1, 16'h0800}));
      chk("abort_d0", 32'(txq[tb + 1]), 32'({1'b0, 16'h1234}));
      chk("abort_d1", 32'(txq[tb + 2]), 32'({1'b0, 16'h5678}));
    end
    m_err = 1'b0;
    wb = wq.size();
    send_word(16'h0843, 1'b1, 1'b0);
    send_word(16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    rx_data = 16'h2222;
    rx_cd = 1'b0;
    rx_done = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b1;
    rx_done = 1'b0;
    #1;
    chk("mrst_we", 32'(mem_we), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_addr", 32'(mem_addr), 0);
    chk("mrst_wdata", 32'(mem_wdata), 0);
    chk("mrst_ready", 32'(tx_ready), 0);
    chk("mrst_txdata", 32'(tx_data), 0);
    chk("mrst_cd", 32'(tx_cd), 0);
    chk("mrst_err", 32'(msg_err), 0);
    chk("mrst_done", 32'(msg_done), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("mrst_wr", wq.size() - wb, 1);
    for (int m = 0; m < 30; m++) begin
      logic [4:0] a, s, wc;
      logic [31:0] pm;
      int r;
      r = $urandom_range(0, 9);
      a = r == 0 ? 5'd2 : r == 1 ? 5'd31 : ADDR;
      r = $urandom_range(0, 7);
      s = r == 0 ? 5'd0 : r == 1 ? 5'd31 : r == 2 ? 5'd7 : 5'($urandom_range(1, NSA));
      wc = 5'($urandom_range(0, 6));
      pm = $urandom_range(0, 3) == 0 ? 32'd1 << $urandom_range(0, 31) : 32'd0;
      do_msg("rnd", {a, 1'($urandom_range(0, 1)), s, wc}, pm, $urandom_range(0, 7) == 0);
    end
    chk("handshake", hs_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
